// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the fetch stage of the 8-bit pipelined core.
package instruction_fetch_unit_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int INSTR_W_DEF = 8;
  localparam int DEPTH_DEF = 2;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;
  localparam logic [7:0] NOP_INSTR = 8'h00;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory read port plus the decode valid/ready handshake.
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               dec_ready;

  // master = fetch unit; slave = memory/decode side
  modport master (
    output imem_addr,
    input  imem_data,
    output if_valid,
    output if_instr,
    output if_pc,
    input  dec_ready
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    output dec_ready
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous prefetch FIFO with first-word-fall-through head and single-cycle flush.
module instruction_fetch_unit_fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic [count_width(DEPTH)-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, prefetches instructions into a FIFO and presents them to decode.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fetch_en,
  input  logic                           branch_valid,
  input  logic [ADDR_W-1:0]              branch_target,
  output logic [count_width(DEPTH)-1:0]  fifo_count,
  instruction_fetch_unit_if.master       bus
);

  localparam int CNT_W = count_width(DEPTH);
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc_reg;
  logic [ADDR_W-1:0]  fetch_pc_next;
  logic               push;
  logic               pop;
  logic               has_room;
  logic               head_valid;
  logic [ENTRY_W-1:0] head_entry;
  logic [CNT_W-1:0]   count;

  assign head_valid = (count != '0);
  assign has_room   = (count < CNT_W'(DEPTH));

  // A redirect suppresses both ends of the FIFO so the stale head is not consumed.
  assign pop  = head_valid & bus.dec_ready & ~branch_valid;
  assign push = fetch_en & ~branch_valid & (has_room | pop);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (branch_valid) begin
      fetch_pc_next = branch_target;
    end else if (push) begin
      fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  instruction_fetch_unit_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (branch_valid),
    .din   ({fetch_pc_reg, bus.imem_data}),
    .head  (head_entry),
    .count (count)
  );

  assign bus.imem_addr = fetch_pc_reg;
  assign bus.if_valid  = head_valid;
  assign bus.if_instr  = head_valid ? head_entry[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign bus.if_pc     = head_valid ? head_entry[ENTRY_W-1:INSTR_W] : '0;
  assign fifo_count    = count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed and randomized checks of the fetch unit against a queue-based reference model.
module tb_instruction_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_en;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       dec_ready;
  logic [1:0] fifo_count;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ins;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mpc;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  assign bus.imem_data = mem[bus.imem_addr];
  assign bus.dec_ready = dec_ready;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .fifo_count    (fifo_count),
    .bus           (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic       ev;
    logic [7:0] ei;
    logic [7:0] ep;
    ev = (q.size() != 0);
    ei = ev ? q[0].ins : 8'h00;
    ep = ev ? q[0].pc : 8'h00;
    chk({tag, ".if_valid"}, 32'(bus.if_valid), 32'(ev));
    chk({tag, ".if_instr"}, 32'(bus.if_instr), 32'(ei));
    chk({tag, ".if_pc"}, 32'(bus.if_pc), 32'(ep));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(mpc));
  endtask

  // Drive one cycle of inputs, check the state visible before the edge, then advance the model.
  task automatic step(input string tag, input logic r, input logic fe, input logic bv,
                      input logic [7:0] bt, input logic dr);
    bit p;
    int sz;
    reset = r;
    fetch_en = fe;
    branch_valid = bv;
    branch_target = bt;
    dec_ready = dr;
    check_model(tag);
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mpc = 8'h00;
    end else if (bv) begin
      q.delete();
      mpc = bt;
    end else begin
      sz = q.size();
      p = (sz > 0) && dr;
      if (p) void'(q.pop_front());
      if (fe && (sz < 2 || p)) begin
        q.push_back({mpc, mem[mpc]});
        mpc = mpc + 8'h01;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h0A;
    mem[1] = 8'h33;
    mem[2] = 8'h4C;
    mem[3] = 8'h75;

    reset = 1'b1;
    fetch_en = 1'b0;
    branch_valid = 1'b0;
    branch_target = 8'h00;
    dec_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    q.delete();
    mpc = 8'h00;

    // Streaming from reset
    step("s1_rst", 1, 1, 0, 8'h00, 1);
    step("s1", 0, 1, 0, 8'h00, 1);
    chk("s1_first_pc", 32'(bus.if_pc), 32'h00);
    chk("s1_first_instr", 32'(bus.if_instr), 32'h0A);
    for (int i = 0; i < 4; i++) step("s1", 0, 1, 0, 8'h00, 1);

    // Back-pressure from reset, then release
    step("s2_rst", 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step("s2_hold", 0, 1, 0, 8'h00, 0);
    chk("s2_full_count", 32'(fifo_count), 32'd2);
    chk("s2_stuck_addr", 32'(bus.imem_addr), 32'h02);
    for (int i = 0; i < 4; i++) step("s2_drain", 0, 1, 0, 8'h00, 1);

    // Redirect while head is valid and decode is ready
    step("s3_rst", 1, 1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step("s3", 0, 1, 0, 8'h00, 1);
    step("s3_br", 0, 1, 1, 8'h02, 1);
    chk("s3_flushed", 32'(bus.if_valid), 32'd0);
    step("s3_tgt", 0, 1, 0, 8'h00, 1);
    chk("s3_tgt_pc", 32'(bus.if_pc), 32'h02);
    chk("s3_tgt_instr", 32'(bus.if_instr), 32'h4C);

    // Redirect near the top of the address space, PC wraps
    step("s4_br", 0, 1, 1, 8'hFE, 1);
    for (int i = 0; i < 3; i++) step("s4", 0, 1, 0, 8'h00, 1);
    chk("s4_wrap_pc", 32'(bus.if_pc), 32'h00);
    chk("s4_wrap_instr", 32'(bus.if_instr), 32'h0A);
    step("s4", 0, 1, 0, 8'h00, 1);

    // fetch_en low drains the FIFO, then fetching resumes
    step("s5_rst", 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) step("s5_fill", 0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step("s5_drain", 0, 0, 0, 8'h00, 1);
    chk("s5_empty", 32'(bus.if_valid), 32'd0);
    chk("s5_addr_held", 32'(bus.imem_addr), 32'h02);
    step("s5_resume", 0, 1, 0, 8'h00, 1);
    chk("s5_resume_pc", 32'(bus.if_pc), 32'h02);
    step("s5_resume", 0, 1, 0, 8'h00, 1);

    // Reset overrides a simultaneous redirect with a full FIFO
    step("s6_rst", 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 2; i++) step("s6_fill", 0, 1, 0, 8'h00, 0);
    step("s6_rst_br", 1, 1, 1, 8'h33, 1);
    chk("s6_valid", 32'(bus.if_valid), 32'd0);
    chk("s6_count", 32'(fifo_count), 32'd0);
    chk("s6_addr", 32'(bus.imem_addr), 32'h00);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic       fe;
      logic       bv;
      logic       dr;
      logic [7:0] bt;
      r  = ($urandom_range(0, 59) == 0);
      fe = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 7) == 0);
      dr = ($urandom_range(0, 2) != 0);
      bt = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(250, 255));
      step("rand", r, fe, bv, bt, dr);
    end
    check_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
